// File: rtl/lzs_pkg.sv
// Shared LZS constants: encoder/decoder state encodings, field widths and prefixes.
// Used by encode_ctl and decode_ctl so both sides agree on the bitstream format.
package lzs_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TOK  = 3'd1,
    S_LEN  = 3'd2,
    S_EXT  = 3'd3,
    S_ENDM = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [3:0]  LIT_W      = 4'd9;
  localparam logic [3:0]  SOFF_W     = 4'd9;
  localparam logic [3:0]  LOFF_W     = 4'd13;
  localparam logic [3:0]  LEN_W2     = 4'd2;
  localparam logic [3:0]  LEN_W4     = 4'd4;
  localparam logic [3:0]  EXT_W      = 4'd4;
  localparam logic [3:0]  END_W      = 4'd9;
  localparam logic [1:0]  SOFF_PFX   = 2'b11;
  localparam logic [1:0]  LOFF_PFX   = 2'b10;
  localparam logic [1:0]  LEN4_PFX   = 2'b11;
  localparam logic [3:0]  EXT_ESC    = 4'hF;
  localparam logic [8:0]  END_MARKER = 9'h180;
  localparam logic [10:0] SOFF_LIMIT = 11'd128;

endpackage

// File: rtl/lzs_len_enc.sv
// Combinational length-code / extension-nibble encoder. In length mode rem holds the
// raw match length; in extension mode it holds the remaining length still to send.
module lzs_len_enc
  import lzs_pkg::*;
#(
  parameter int LW = 12
) (
  input  logic          is_ext,
  input  logic [LW-1:0] rem,
  output logic [12:0]   code,
  output logic [3:0]    width,
  output logic [LW-1:0] rem_nxt,
  output logic          last
);

  logic [LW-1:0] rem_m8_s;
  logic [LW-1:0] rem_m15_s;

  assign rem_m8_s  = rem - LW'(8);
  assign rem_m15_s = rem - LW'(15);

  // Select the field for the current length/extension step and the remainder after it.
  always_comb begin
    code    = 13'd0;
    width   = 4'd0;
    rem_nxt = '0;
    last    = 1'b1;
    if (is_ext) begin
      if (rem >= LW'(15)) begin
        code    = {9'd0, EXT_ESC};
        width   = EXT_W;
        rem_nxt = rem_m15_s;
        last    = 1'b0;
      end else begin
        code    = {9'd0, rem[3:0]};
        width   = EXT_W;
        rem_nxt = '0;
        last    = 1'b1;
      end
    end else if (rem < LW'(5)) begin
      // lengths 2..4 map to 0..2 using only the low bits
      code    = {11'd0, rem[1:0] - 2'd2};
      width   = LEN_W2;
      rem_nxt = '0;
      last    = 1'b1;
    end else if (rem < LW'(8)) begin
      code    = {9'd0, LEN4_PFX, rem[1:0] - 2'd1};
      width   = LEN_W4;
      rem_nxt = '0;
      last    = 1'b1;
    end else begin
      code    = {9'd0, EXT_ESC};
      width   = LEN_W4;
      rem_nxt = rem_m8_s;
      last    = 1'b0;
    end
  end

endmodule

// File: rtl/encode_ctl.sv
// LZS encoder back-end: turns literal/match tokens into variable-width code fields
// held in a single registered output slot for the downstream bit packer.
module encode_ctl
  import lzs_pkg::*;
#(
  parameter int LW = 12,
  parameter int SW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          tok_valid,
  output logic          tok_ack,
  input  logic          tok_match,
  input  logic [7:0]    tok_lit,
  input  logic [10:0]   tok_off,
  input  logic [LW-1:0] tok_len,
  input  logic          in_done,
  output logic [12:0]   code_data,
  output logic [3:0]    code_width,
  output logic          code_valid,
  input  logic          code_ack,
  output logic          out_done,
  output logic          err,
  output logic [SW-1:0] stat_bits,
  output logic [2:0]    encode_ctl_state
);

  state_t        state_r, state_s;
  logic [LW-1:0] rem_r, rem_s;
  logic [12:0]   code_data_r, ld_data_s;
  logic [3:0]    code_width_r, ld_width_s;
  logic          code_valid_r;
  logic          load_s, ack_s, err_r, err_set_s, slot_free_s, illegal_s;
  logic [SW-1:0] stat_r;
  logic [12:0]   enc_code_s;
  logic [3:0]    enc_width_s;
  logic [LW-1:0] enc_rem_s;
  logic          enc_last_s;

  assign slot_free_s = !code_valid_r || code_ack;
  assign illegal_s   = (tok_len < LW'(2)) || (tok_off == 11'd0);

  lzs_len_enc #(.LW(LW)) u_len_enc (
    .is_ext  (state_r == S_EXT),
    .rem     (rem_r),
    .code    (enc_code_s),
    .width   (enc_width_s),
    .rem_nxt (enc_rem_s),
    .last    (enc_last_s)
  );

  // Next-state, slot load request and token handshake.
  always_comb begin
    state_s    = state_r;
    rem_s      = rem_r;
    load_s     = 1'b0;
    ld_data_s  = 13'd0;
    ld_width_s = 4'd0;
    ack_s      = 1'b0;
    err_set_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (ce) state_s = S_TOK;
        else    state_s = S_IDLE;
      end
      S_TOK: begin
        if (rst && tok_valid && slot_free_s) begin
          ack_s = 1'b1;
          if (!tok_match) begin
            load_s     = 1'b1;
            ld_data_s  = {4'd0, 1'b0, tok_lit};
            ld_width_s = LIT_W;
          end else if (illegal_s) begin
            err_set_s = 1'b1;
          end else begin
            load_s  = 1'b1;
            rem_s   = tok_len;
            state_s = S_LEN;
            if (tok_off < SOFF_LIMIT) begin
              ld_data_s  = {4'd0, SOFF_PFX, tok_off[6:0]};
              ld_width_s = SOFF_W;
            end else begin
              ld_data_s  = {LOFF_PFX, tok_off};
              ld_width_s = LOFF_W;
            end
          end
        end else if (!tok_valid && in_done) begin
          state_s = S_ENDM;
        end else begin
          state_s = S_TOK;
        end
      end
      S_LEN, S_EXT: begin
        if (slot_free_s) begin
          load_s     = 1'b1;
          ld_data_s  = enc_code_s;
          ld_width_s = enc_width_s;
          rem_s      = enc_rem_s;
          state_s    = enc_last_s ? S_TOK : S_EXT;
        end else begin
          state_s = state_r;
        end
      end
      S_ENDM: begin
        if (slot_free_s) begin
          load_s     = 1'b1;
          ld_data_s  = {4'd0, END_MARKER};
          ld_width_s = END_W;
          state_s    = S_DONE;
        end else begin
          state_s = S_ENDM;
        end
      end
      S_DONE: begin
        if (!ce) state_s = S_IDLE;
        else     state_s = S_DONE;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State, output slot, sticky error and transferred-bit counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      rem_r        <= '0;
      code_data_r  <= 13'd0;
      code_width_r <= 4'd0;
      code_valid_r <= 1'b0;
      err_r        <= 1'b0;
      stat_r       <= '0;
    end else begin
      state_r <= state_s;
      rem_r   <= rem_s;
      err_r   <= err_r | err_set_s;
      if (code_valid_r && code_ack) stat_r <= stat_r + SW'(code_width_r);
      if (load_s) begin
        code_data_r  <= ld_data_s;
        code_width_r <= ld_width_s;
        code_valid_r <= 1'b1;
      end else if (code_valid_r && code_ack) begin
        code_valid_r <= 1'b0;
      end
    end
  end

  assign tok_ack          = ack_s;
  assign code_data        = code_data_r;
  assign code_width       = code_width_r;
  assign code_valid       = code_valid_r;
  assign out_done         = (state_r == S_DONE) && !code_valid_r;
  assign err              = err_r;
  assign stat_bits        = stat_r;
  assign encode_ctl_state = state_r;

endmodule
